issue_queue: RTL and testbench
==============================

# issue_queue

In-order buffer between the decoder and the dispatch/execute stage. It accepts one decoded `ISSUE_QUEUE_ELEMENT` per cycle and holds it in a circular FIFO. Entries are presented oldest-first to dispatch under a valid/ready handshake. A branch-mispredict flush discards all buffered entries. The queue decouples decode from execute back-pressure and sits directly downstream of `decoder`.

## Interface
Parameters:
- `DEPTH`, 8: number of entries; must be a power of two, ≥2.
- `PTR_W`, $clog2(DEPTH): pointer width (derived, not overridden).

Ports:
- `clk` input 1: clock; all state updates on rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `flush` input 1: discard all entries (mispredict/redirect).
- `enq_valid` input 1: decoder presents a valid element.
- `enq_elem` input ISSUE_QUEUE_ELEMENT: decoded element to store.
- `enq_ready` output 1: queue can accept this cycle.
- `deq_valid` output 1: head entry valid.
- `deq_elem` output ISSUE_QUEUE_ELEMENT: head (oldest) entry.
- `deq_ready` input 1: dispatch consumes head this cycle.
- `count` output PTR_W+1: current occupancy, 0..DEPTH.

## Operation
- Storage: DEPTH-entry array of `ISSUE_QUEUE_ELEMENT`, plus head pointer `head`, tail pointer `tail` (PTR_W bits each), and `count`.
- Enqueue fire: `enq_valid && enq_ready && !flush`. The element is written at `tail` and `tail` increments mod DEPTH.
- Dequeue fire: `deq_valid && deq_ready && !flush`. `head` increments mod DEPTH.
- `enq_ready = (count != DEPTH)`. It depends on registered state only. There is no combinational path from `deq_ready`, so when full, a simultaneous dequeue does not admit an enqueue in that cycle.
- `deq_valid = (count != 0)`. `deq_elem = mem[head]`, a mux from registers with no fall-through. When empty, `deq_elem` is don't-care; the bench checks it only with `deq_valid`.
- Count update:
  - +1 on enqueue only.
  - −1 on dequeue only.
  - Unchanged on both, or on neither.
- Wrap-around: pointers wrap naturally at DEPTH. Full and empty are distinguished solely by `count`.
- Flush: `head`, `tail` and `count` go to 0 on the next edge. Flush wins over same-cycle enq/deq: neither fires, and the element on `enq_elem` that cycle is dropped. The array contents are not cleared.
- Reset: identical effect to flush. If asserted mid-operation, all in-flight entries are lost.
- Element fields pass through bit-exact. The queue never inspects or modifies `pc`, `exe_type`, `accept_mask`, `predict_*`, etc.

## Timing
- Reset values:
  - `count` = 0.
  - `deq_valid` = 0.
  - `enq_ready` = 1.
  - `head` = `tail` = 0.
- Latency: an element enqueued at edge N is visible on `deq_elem` with `deq_valid`=1 in cycle N+1 (after edge N) at the earliest. Minimum occupancy time is one cycle.
- Throughput: one enqueue and one dequeue per cycle sustained while 0 < count < DEPTH.
- Handshake: the decoder holds `enq_elem` stable while `enq_valid` && !`enq_ready`. The queue holds `deq_elem` stable while `deq_valid` && !`deq_ready`.
- After flush at edge N: in cycle N+1, `deq_valid`=0, `enq_ready`=1, `count`=0.

## Structure
- `ISSUE_QUEUE_ELEMENT` and its enum fields (`exe_type`, `alu_op`, `brunch_type`, `llu_op`, `mem_type`) stay in the shared defines/package. The queue adds no new types.
- The default `DEPTH` constant belongs in the shared package as `ISSUE_QUEUE_DEPTH`.
- Single module. The storage array is inline registers; no sub-module is needed.

## Test plan
- Reset, then idle: `count`=0, `deq_valid`=0, `enq_ready`=1. Enqueue ORI element with pc=0x1000 → next cycle `deq_valid`=1, `deq_elem.pc`=0x1000, `count`=1.
- Enqueue 8 elements (pc 0x0,0x4,…,0x1C) with `deq_ready`=0:
  - After the 8th, `enq_ready`=0 and `count`=8.
  - A 9th `enq_valid` is not accepted.
  - Then dequeue all 8 → pcs emerge in order 0x0..0x1C, ending at `count`=0.
- Sustained streaming, `enq_valid`=`deq_ready`=1 for 20 cycles, pcs incrementing:
  - `count` stays at 1 after the first cycle.
  - Output pc order matches input order across two pointer wraps.
- Full with `deq_ready`=1 and `enq_valid`=1 in the same cycle → dequeue fires, enqueue does not. `count` becomes 7, then next cycle the enqueue is accepted and `count`=8.
- With 5 entries held, assert `flush` together with `enq_valid` and `deq_ready` → next cycle `count`=0 and `deq_valid`=0. The flushed-cycle element never appears on `deq_elem`.
- Assert `rst` with 3 entries held and `enq_valid`=1 → next cycle `count`=0 and `deq_valid`=0. A following enqueue of pc=0x2000 appears at the head.

Source files
------------

// File: rtl/issue_queue_pkg.sv
// Shared decode/issue types: the issue queue element, its enum fields and the default queue depth.
package issue_queue_pkg;

  localparam int unsigned XLEN              = 32;
  localparam int unsigned REG_IDX_W         = 5;
  localparam int unsigned ACCEPT_MASK_W     = 4;
  localparam int unsigned ISSUE_QUEUE_DEPTH = 8;

  typedef enum logic [1:0] {
    EXE_ALU = 2'd0,
    EXE_BRU = 2'd1,
    EXE_LLU = 2'd2,
    EXE_MEM = 2'd3
  } exe_type_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_LUI  = 4'd10
  } alu_op_t;

  typedef enum logic [3:0] {
    BR_NONE = 4'd0,
    BR_BEQ  = 4'd1,
    BR_BNE  = 4'd2,
    BR_BLT  = 4'd3,
    BR_BGE  = 4'd4,
    BR_BLTU = 4'd5,
    BR_BGEU = 4'd6,
    BR_JAL  = 4'd7,
    BR_JALR = 4'd8
  } brunch_type_t;

  typedef enum logic [1:0] {
    LLU_MUL  = 2'd0,
    LLU_MULH = 2'd1,
    LLU_DIV  = 2'd2,
    LLU_REM  = 2'd3
  } llu_op_t;

  typedef enum logic [2:0] {
    MEM_LB  = 3'd0,
    MEM_LH  = 3'd1,
    MEM_LW  = 3'd2,
    MEM_LBU = 3'd3,
    MEM_LHU = 3'd4,
    MEM_SB  = 3'd5,
    MEM_SH  = 3'd6,
    MEM_SW  = 3'd7
  } mem_type_t;

  typedef struct packed {
    logic [XLEN-1:0]          pc;
    exe_type_t                exe_type;
    alu_op_t                  alu_op;
    brunch_type_t             brunch_type;
    llu_op_t                  llu_op;
    mem_type_t                mem_type;
    logic [REG_IDX_W-1:0]     rd;
    logic [REG_IDX_W-1:0]     rs1;
    logic [REG_IDX_W-1:0]     rs2;
    logic [XLEN-1:0]          imm;
    logic                     use_imm;
    logic [ACCEPT_MASK_W-1:0] accept_mask;
    logic                     predict_taken;
    logic [XLEN-1:0]          predict_target;
  } ISSUE_QUEUE_ELEMENT;

endpackage

// File: rtl/issue_queue.sv
// In-order circular FIFO between decode and dispatch; flush/reset drop every buffered entry.
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int unsigned  DEPTH = ISSUE_QUEUE_DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               enq_valid,
  input  ISSUE_QUEUE_ELEMENT enq_elem,
  output logic               enq_ready,
  output logic               deq_valid,
  output ISSUE_QUEUE_ELEMENT deq_elem,
  input  logic               deq_ready,
  output logic [PTR_W:0]     count
);

  localparam int unsigned CNT_W = PTR_W + 1;

  ISSUE_QUEUE_ELEMENT r_mem [DEPTH];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;

  logic w_enq_fire;
  logic w_deq_fire;
  logic w_clear;

  // Ready/valid come only from the occupancy register, so deq_ready never gates enqueue.
  assign enq_ready  = (r_count != CNT_W'(DEPTH));
  assign deq_valid  = (r_count != CNT_W'(0));
  assign deq_elem   = r_mem[r_head];
  assign count      = r_count;

  assign w_clear    = rst || flush;
  assign w_enq_fire = enq_valid && enq_ready && !w_clear;
  assign w_deq_fire = deq_valid && deq_ready && !w_clear;

  // Pointer and occupancy update; reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq_fire) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_deq_fire) begin
        r_head <= r_head + PTR_W'(1);
      end
      if (w_enq_fire && !w_deq_fire) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_deq_fire && !w_enq_fire) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Storage write at the tail; contents are intentionally left untouched by flush/reset.
  always_ff @(posedge clk) begin
    if (w_enq_fire) begin
      r_mem[r_tail] <= enq_elem;
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Directed self-checking bench for issue_queue.
module tb_issue_queue;
  import issue_queue_pkg::*;

  logic               clk;
  logic               rst;
  logic               flush;
  logic               enq_valid;
  ISSUE_QUEUE_ELEMENT enq_elem;
  logic               enq_ready;
  logic               deq_valid;
  ISSUE_QUEUE_ELEMENT deq_elem;
  logic               deq_ready;
  logic [3:0]         count;

  int n_tests;
  int n_fail;

  issue_queue #(.DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .enq_valid (enq_valid),
    .enq_elem  (enq_elem),
    .enq_ready (enq_ready),
    .deq_valid (deq_valid),
    .deq_elem  (deq_elem),
    .deq_ready (deq_ready),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic ISSUE_QUEUE_ELEMENT make_elem(input logic [31:0] pc);
    ISSUE_QUEUE_ELEMENT e;
    e                = '0;
    e.pc             = pc;
    e.exe_type       = EXE_ALU;
    e.alu_op         = ALU_OR;
    e.brunch_type    = BR_NONE;
    e.llu_op         = LLU_MUL;
    e.mem_type       = MEM_LW;
    e.rd             = pc[6:2];
    e.rs1            = 5'd1;
    e.rs2            = 5'd2;
    e.imm            = ~pc;
    e.use_imm        = 1'b1;
    e.accept_mask    = pc[5:2];
    e.predict_taken  = pc[2];
    e.predict_target = pc + 32'h40;
    return e;
  endfunction

  task automatic push(input logic [31:0] pc);
    enq_valid = 1'b1;
    enq_elem  = make_elem(pc);
    step();
    enq_valid = 1'b0;
  endtask

  initial begin
    ISSUE_QUEUE_ELEMENT exp_e;
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    enq_valid = 1'b0;
    enq_elem  = '0;
    deq_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();

    // Reset / idle state
    check("rst_count", 32'(count), 32'd0);
    check("rst_deq_valid", 32'(deq_valid), 32'd0);
    check("rst_enq_ready", 32'(enq_ready), 32'd1);

    // Single ORI element, one-cycle latency, bit-exact passthrough
    exp_e = make_elem(32'h1000);
    push(32'h1000);
    check("ori_deq_valid", 32'(deq_valid), 32'd1);
    check("ori_pc", deq_elem.pc, 32'h1000);
    check("ori_count", 32'(count), 32'd1);
    check("ori_alu_op", 32'(deq_elem.alu_op), 32'(ALU_OR));
    check("ori_exact", 32'(deq_elem == exp_e), 32'd1);
    deq_ready = 1'b1;
    step();
    deq_ready = 1'b0;
    check("ori_drain_count", 32'(count), 32'd0);

    // Fill to 8, reject 9th, drain in order
    for (int i = 0; i < 8; i++) push(32'(i * 4));
    check("full_count", 32'(count), 32'd8);
    check("full_enq_ready", 32'(enq_ready), 32'd0);
    push(32'h99);
    check("ninth_count", 32'(count), 32'd8);
    check("ninth_head", deq_elem.pc, 32'h0);
    for (int i = 0; i < 8; i++) begin
      check("drain_valid", 32'(deq_valid), 32'd1);
      check("drain_pc", deq_elem.pc, 32'(i * 4));
      deq_ready = 1'b1;
      step();
      deq_ready = 1'b0;
    end
    check("drain_count", 32'(count), 32'd0);
    check("drain_deq_valid", 32'(deq_valid), 32'd0);

    // Sustained streaming for 20 cycles across pointer wraps
    enq_valid = 1'b1;
    deq_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      enq_elem = make_elem(32'h100 + 32'(i * 4));
      step();
      check("stream_count", 32'(count), 32'd1);
      check("stream_pc", deq_elem.pc, 32'h100 + 32'(i * 4));
    end
    enq_valid = 1'b0;
    step();
    deq_ready = 1'b0;
    check("stream_end_count", 32'(count), 32'd0);

    // Full with simultaneous enq/deq: only dequeue fires
    for (int i = 0; i < 8; i++) push(32'h200 + 32'(i * 4));
    check("full2_count", 32'(count), 32'd8);
    enq_valid = 1'b1;
    enq_elem  = make_elem(32'h300);
    deq_ready = 1'b1;
    step();
    deq_ready = 1'b0;
    check("full_deq_only_count", 32'(count), 32'd7);
    check("full_deq_only_ready", 32'(enq_ready), 32'd1);
    step();
    enq_valid = 1'b0;
    check("full_refill_count", 32'(count), 32'd8);
    check("full_refill_head", deq_elem.pc, 32'h204);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_clean_count", 32'(count), 32'd0);

    // Flush with 5 entries and simultaneous enq/deq
    for (int i = 0; i < 5; i++) push(32'h400 + 32'(i * 4));
    check("five_count", 32'(count), 32'd5);
    flush     = 1'b1;
    enq_valid = 1'b1;
    enq_elem  = make_elem(32'hDEAD);
    deq_ready = 1'b1;
    step();
    flush     = 1'b0;
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    check("flush_count", 32'(count), 32'd0);
    check("flush_deq_valid", 32'(deq_valid), 32'd0);
    check("flush_enq_ready", 32'(enq_ready), 32'd1);
    push(32'h500);
    check("post_flush_count", 32'(count), 32'd1);
    check("post_flush_pc", deq_elem.pc, 32'h500);
    step();
    check("post_flush_hold_pc", deq_elem.pc, 32'h500);

    // Reset mid-operation with enqueue asserted
    push(32'h600);
    push(32'h604);
    check("three_count", 32'(count), 32'd3);
    rst       = 1'b1;
    enq_valid = 1'b1;
    enq_elem  = make_elem(32'hBEEF);
    step();
    rst       = 1'b0;
    enq_valid = 1'b0;
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_deq_valid", 32'(deq_valid), 32'd0);
    push(32'h2000);
    check("after_rst_pc", deq_elem.pc, 32'h2000);
    check("after_rst_count", 32'(count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
